// File: rtl/seg_scan_reader.sv
// seg_scan_reader: reads a multiplexed 4-digit seven-segment display back
// into a 16-bit value. It settles each strobed glyph, decodes it, assembles
// complete frames, and publishes a value once enough identical frames arrive.
module seg_scan_reader #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int MATCH_FRAMES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel1,
    input  logic        sel2,
    input  logic        sel3,
    input  logic        sel4,
    input  logic [7:0]  seg,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        hex_digits,
    output logic [3:0]  dp_out,
    output logic        glyph_err,
    output logic        sel_err,
    output logic        stale
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    SETTLE_L = 4'(SETTLE_CYCLES);
    localparam logic [2:0]    MATCH_L  = 3'(MATCH_FRAMES);
    localparam logic [TW-1:0] TO_L     = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

    // Maps seg[6:0] to {valid, nibble}; anything outside the 16 glyphs is invalid.
    function automatic logic [4:0] decodeGlyph(input logic [6:0] g);
        case (g)
            7'h3F: decodeGlyph = 5'h10;
            7'h06: decodeGlyph = 5'h11;
            7'h5B: decodeGlyph = 5'h12;
            7'h4F: decodeGlyph = 5'h13;
            7'h66: decodeGlyph = 5'h14;
            7'h6D: decodeGlyph = 5'h15;
            7'h7D: decodeGlyph = 5'h16;
            7'h07: decodeGlyph = 5'h17;
            7'h7F: decodeGlyph = 5'h18;
            7'h6F: decodeGlyph = 5'h19;
            7'h77: decodeGlyph = 5'h1A;
            7'h7C: decodeGlyph = 5'h1B;
            7'h39: decodeGlyph = 5'h1C;
            7'h5E: decodeGlyph = 5'h1D;
            7'h79: decodeGlyph = 5'h1E;
            7'h71: decodeGlyph = 5'h1F;
            default: decodeGlyph = 5'h00;
        endcase
    endfunction

    state_t          r_state, w_stateNext;
    logic [3:0]      r_cnt, w_cntNext;
    logic [7:0]      r_seg, w_segNext;
    logic [1:0]      r_idx, w_idxNext;
    logic [3:0][3:0] r_slots, w_slotsNext;
    logic [3:0]      r_dps, w_dpsNext;
    logic [3:0]      r_mask, w_maskNext;
    logic [19:0]     r_prevFrame;
    logic [2:0]      r_match, w_matchNext;
    logic [TW-1:0]   r_toCnt;
    logic [15:0]     r_value;
    logic [3:0]      r_dpOut;
    logic            r_hex, r_valid, r_glyphErr, r_selErr, r_stale;

    logic [3:0]  w_sel;
    logic [1:0]  w_idx;
    logic        w_one, w_multi, w_sample, w_start;
    logic [4:0]  w_dec;
    logic        w_captureOk, w_glyphBad, w_frameDone, w_same, w_publish;
    logic        w_hexNext, w_timeoutHit;
    logic [19:0] w_frame;

    assign w_sel   = {sel4, sel3, sel2, sel1};
    assign w_one   = $onehot(w_sel);
    assign w_multi = (w_sel != 4'd0) && !w_one;
    assign w_dec   = decodeGlyph(seg[6:0]);

    // Index of the single active strobe.
    always_comb begin
        w_idx = 2'd0;
        case (w_sel)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // Capture FSM: settle a glyph under one strobe, sample once, then hold.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_segNext   = r_seg;
        w_idxNext   = r_idx;
        w_sample    = 1'b0;
        w_start     = 1'b0;
        if (w_multi) begin
            w_stateNext = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_one) w_start = 1'b1;
                end
                S_SETTLE: begin
                    if (!w_one) begin
                        w_stateNext = S_IDLE;
                    end else if (w_idx == r_idx && seg == r_seg) begin
                        if (r_cnt + 4'd1 == SETTLE_L) begin
                            w_sample    = 1'b1;
                            w_stateNext = S_HOLD;
                        end else begin
                            w_cntNext = r_cnt + 4'd1;
                        end
                    end else begin
                        w_start = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!w_one) w_stateNext = S_IDLE;
                    else if (w_idx != r_idx) w_start = 1'b1;
                end
                default: w_stateNext = S_IDLE;
            endcase
        end
        if (w_start) begin
            w_stateNext = S_SETTLE;
            w_cntNext   = 4'd1;
            w_segNext   = seg;
            w_idxNext   = w_idx;
            if (SETTLE_L == 4'd1) begin
                w_sample    = 1'b1;
                w_stateNext = S_HOLD;
            end
        end
    end

    // Capture FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_seg   <= 8'd0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_seg   <= w_segNext;
            r_idx   <= w_idxNext;
        end
    end

    assign w_captureOk = w_sample && w_dec[4];
    assign w_glyphBad  = w_sample && !w_dec[4];

    // Slot update, frame assembly, match counting and publish decision.
    always_comb begin
        w_slotsNext = r_slots;
        w_dpsNext   = r_dps;
        w_maskNext  = r_mask;
        w_hexNext   = 1'b0;
        if (w_captureOk) begin
            w_slotsNext[w_idx] = w_dec[3:0];
            w_dpsNext[w_idx]   = seg[7];
            w_maskNext[w_idx]  = 1'b1;
        end
        w_frameDone = &w_maskNext;
        w_frame     = {w_slotsNext, w_dpsNext};
        w_same      = (w_frame == r_prevFrame);
        if (w_same) w_matchNext = (r_match >= MATCH_L) ? MATCH_L : r_match + 3'd1;
        else        w_matchNext = 3'd1;
        w_publish = w_frameDone && (w_matchNext == MATCH_L) && !(w_same && r_match == MATCH_L);
        for (int i = 0; i < 4; i++) begin
            if (w_slotsNext[i] > 4'd9) w_hexNext = 1'b1;
        end
        w_timeoutHit = !w_captureOk && (r_toCnt != TO_L) && (r_toCnt + TW'(1) == TO_L);
    end

    // Datapath registers: slots, frame history, timeout and published outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slots     <= '0;
            r_dps       <= 4'd0;
            r_mask      <= 4'd0;
            r_prevFrame <= 20'd0;
            r_match     <= 3'd0;
            r_toCnt     <= '0;
            r_value     <= 16'd0;
            r_dpOut     <= 4'd0;
            r_hex       <= 1'b0;
            r_valid     <= 1'b0;
            r_glyphErr  <= 1'b0;
            r_selErr    <= 1'b0;
            r_stale     <= 1'b1;
        end else begin
            r_glyphErr <= w_glyphBad;
            r_selErr   <= w_multi;
            r_valid    <= w_publish;
            if (w_captureOk)          r_toCnt <= '0;
            else if (r_toCnt != TO_L) r_toCnt <= r_toCnt + TW'(1);
            if (w_timeoutHit) begin
                r_mask  <= 4'd0;
                r_match <= 3'd0;
                r_stale <= 1'b1;
            end else begin
                r_slots <= w_slotsNext;
                r_dps   <= w_dpsNext;
                if (w_frameDone) begin
                    r_mask      <= 4'd0;
                    r_match     <= w_matchNext;
                    r_prevFrame <= w_frame;
                end else begin
                    r_mask <= w_maskNext;
                end
                if (w_publish) begin
                    r_value <= w_slotsNext;
                    r_dpOut <= w_dpsNext;
                    r_hex   <= w_hexNext;
                    r_stale <= 1'b0;
                end
            end
        end
    end

    assign value       = r_value;
    assign value_valid = r_valid;
    assign hex_digits  = r_hex;
    assign dp_out      = r_dpOut;
    assign glyph_err   = r_glyphErr;
    assign sel_err     = r_selErr;
    assign stale       = r_stale;

endmodule
